// File: rtl/uart_pkg.sv
// Shared types and register map for the Wishbone UART transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    // Register select, decoded from ADR[3:2]
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;

    // STATUS bit positions
    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;

    // STATUS word as seen on DAT_O
    typedef struct packed {
        logic [28:0] rsvd;
        logic        busy;
        logic        empty;
        logic        full;
    } uart_status_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Generic synchronous FIFO holding bytes queued for the serialiser.
// Latency: dout shows the head entry combinationally; a push is visible one cycle later.
// Backpressure: push ignored when full, pop ignored when empty; full is judged before a same-cycle pop.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == (AW + 1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // Pointer and occupancy update; simultaneous push and pop leave count unchanged
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AW + 1)'(1);
        end
    end

    // Control state; reset empties the queue without touching storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/wb_uart_tx.sv
// Wishbone classic slave that queues bytes and shifts them out 8N1 on tx.
// Latency: termination one edge after request; tx falls 2 clk after the ACK edge into an empty FIFO.
// Backpressure: DATA write into a full FIFO terminates with RTY and is dropped; the master retries.
module wb_uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CYC,
    input  logic        STB,
    input  logic        WE,
    input  logic [31:0] ADR,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    output logic        ACK,
    output logic        ERR,
    output logic        RTY,
    output logic        tx,
    output logic        tx_idle
);

    localparam int             BW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLK_DIV - 1);

    // Bus side
    logic         ack_q, ack_d;
    logic         err_q, err_d;
    logic         rty_q, rty_d;
    logic [31:0]  dat_o_q, dat_o_d;
    logic         req;
    uart_status_t status;

    // Serialiser
    uart_tx_state_t state_q, state_d;
    logic [BW-1:0]  baud_q, baud_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic           tx_q, tx_d;
    logic           tx_idle_q, tx_idle_d;
    logic           baud_end;

    // FIFO
    logic                          push, pop;
    logic                          fifo_full, fifo_empty;
    logic [7:0]                    fifo_dout;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;

    // Address bits above the window are already decoded into CYC; byte lanes below [31:24] carry nothing
    logic unused_bits;
    assign unused_bits = ^{ADR[31:4], ADR[1:0], DAT_I[23:0], fifo_count};

    uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (push),
        .pop   (pop),
        .din   (DAT_I[31:24]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A request is blocked while its own termination is on the bus, so a held STB cannot double-push
    assign req      = CYC && STB && !(ack_q || err_q || rty_q);
    assign baud_end = (baud_q == BAUD_LAST);

    // Bus decode: pick exactly one termination and the read data for the next cycle
    always_comb begin
        status       = '0;
        status.full  = fifo_full;
        status.empty = fifo_empty;
        status.busy  = (state_q != IDLE);
        ack_d        = 1'b0;
        err_d        = 1'b0;
        rty_d        = 1'b0;
        dat_o_d      = '0;
        push         = 1'b0;
        if (req) begin
            case (ADR[3:2])
                REG_DATA: begin
                    if (!WE) begin
                        ack_d = 1'b1;
                    end else if (fifo_full) begin
                        rty_d = 1'b1;
                    end else begin
                        ack_d = 1'b1;
                        push  = 1'b1;
                    end
                end
                REG_STATUS: begin
                    if (WE) begin
                        err_d = 1'b1;
                    end else begin
                        ack_d   = 1'b1;
                        dat_o_d = status;
                    end
                end
                default: err_d = 1'b1;
            endcase
        end
    end

    // Serialiser: line level follows the registered state, so tx lags a state change by one clk
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        tx_d    = 1'b1;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (baud_end) begin
                    baud_d = '0;
                    bit_d  = '0;
                    // Chain straight into the next frame when more data is queued
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_dout;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        tx_idle_d = fifo_empty && (state_q == IDLE);
    end

    // All registered state; reset aborts any frame and drives the line idle at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rty_q     <= 1'b0;
            dat_o_q   <= '0;
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            tx_idle_q <= 1'b1;
        end else begin
            ack_q     <= ack_d;
            err_q     <= err_d;
            rty_q     <= rty_d;
            dat_o_q   <= dat_o_d;
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            tx_idle_q <= tx_idle_d;
        end
    end

    assign ACK     = ack_q;
    assign ERR     = err_q;
    assign RTY     = rty_q;
    assign DAT_O   = dat_o_q;
    assign tx      = tx_q;
    assign tx_idle = tx_idle_q;

endmodule

// File: tb/tb_wb_uart_tx.sv
// Self-checking bench for wb_uart_tx: directed bus scenarios plus a randomized byte stream.
// Latency: n/a.
// Backpressure: RTY terminations are retried by the bench.
module tb_wb_uart_tx;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int BIT_T      = CLK_DIV * 10;

    localparam logic [2:0]  T_ACK = 3'b100;
    localparam logic [2:0]  T_ERR = 3'b010;
    localparam logic [2:0]  T_RTY = 3'b001;

    localparam logic [31:0] A_DATA = 32'h0000_fff0;
    localparam logic [31:0] A_STAT = 32'h0000_fff4;
    localparam logic [31:0] A_R2   = 32'h0000_fff8;
    localparam logic [31:0] A_R3   = 32'h0000_fffc;

    logic        clk;
    logic        rst;
    logic        CYC, STB, WE;
    logic [31:0] ADR, DAT_I, DAT_O;
    logic        ACK, ERR, RTY;
    logic        tx, tx_idle;

    int          n_chk = 0;
    int          n_bad = 0;
    bit          mon_en = 1'b0;
    logic [7:0]  exp_q[$];
    logic [7:0]  rx_q[$];

    wb_uart_tx #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .CYC     (CYC),
        .STB     (STB),
        .WE      (WE),
        .ADR     (ADR),
        .DAT_I   (DAT_I),
        .DAT_O   (DAT_O),
        .ACK     (ACK),
        .ERR     (ERR),
        .RTY     (RTY),
        .tx      (tx),
        .tx_idle (tx_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Ideal 8N1 line, one sample per clk, frames back to back
    function automatic logic [127:0] line_model(input logic [7:0] b0, input logic [7:0] b1, input int nframes);
        logic [127:0] v;
        logic [7:0]   b;
        int           bitn;
        v = '0;
        for (int t = 0; t < nframes * 10 * CLK_DIV; t++) begin
            b    = (t / (10 * CLK_DIV) == 0) ? b0 : b1;
            bitn = (t % (10 * CLK_DIV)) / CLK_DIV;
            if (bitn == 0)      v[t] = 1'b0;
            else if (bitn == 9) v[t] = 1'b1;
            else                v[t] = b[bitn - 1];
        end
        return v;
    endfunction

    // Independent UART receiver: samples the middle of each bit after a falling start edge
    initial begin
        forever begin
            @(negedge tx);
            if (mon_en) begin
                logic [7:0] mb;
                #15;
                chk("mon_start", 128'(tx), 128'(0));
                for (int i = 0; i < 8; i++) begin
                    #(BIT_T);
                    mb[i] = tx;
                end
                #(BIT_T);
                chk("mon_stop", 128'(tx), 128'(1));
                rx_q.push_back(mb);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full handshake: raise STB, wait for a termination, drop STB in the termination cycle
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                           output logic [2:0] term, output logic [31:0] rdat);
        tick();
        CYC = 1'b1; STB = 1'b1; WE = we; ADR = adr; DAT_I = wdat;
        term = '0;
        rdat = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ACK || ERR || RTY) begin
                term = {ACK, ERR, RTY};
                rdat = DAT_O;
                break;
            end
        end
        CYC = 1'b0; STB = 1'b0; WE = 1'b0;
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic [2:0] term);
        logic [31:0] rdat;
        wb_xfer(1'b1, A_DATA | 32'($urandom_range(0, 3)), {b, 24'($urandom)}, term, rdat);
        if (term == T_ACK) exp_q.push_back(b);
    endtask

    // Single-edge request: caller is just after a rising edge; request lands on the next one
    task automatic one_wr(input logic [7:0] b, output logic [2:0] term);
        CYC = 1'b1; STB = 1'b1; WE = 1'b1; ADR = A_DATA; DAT_I = {b, 24'h0};
        tick();
        term = {ACK, ERR, RTY};
        CYC = 1'b0; STB = 1'b0; WE = 1'b0;
        if (term == T_ACK) exp_q.push_back(b);
    endtask

    task automatic capture(input int n, output logic [127:0] v, output int lat);
        v   = '0;
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (!tx) begin
                lat = i;
                break;
            end
        end
        if (lat != 0) begin
            v[0] = tx;
            for (int t = 1; t < n; t++) begin
                @(negedge clk);
                v[t] = tx;
            end
        end
    endtask

    task automatic wait_idle(input int max, input string tag);
        repeat (3) @(negedge clk);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (tx_idle) break;
        end
        repeat (2) @(negedge clk);
        chk(tag, 128'(tx_idle), 128'(1));
    endtask

    task automatic sb_check(input string tag);
        chk({tag, "_count"}, 128'(rx_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            chk({tag, "_byte"}, 128'(rx_q[i]), 128'(exp_q[i]));
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    logic [2:0]   term, t3a, t3b;
    logic [31:0]  rd;
    logic [127:0] cap, cap3, model;
    int           lat, lat3, edges, n_ack;
    logic         prev, exp_bit;
    logic [7:0]   cur, b6;
    logic [9:0]   ackv, expv;
    logic         other;

    initial begin
        rst = 1'b0;
        CYC = 1'b0; STB = 1'b0; WE = 1'b0; ADR = '0; DAT_I = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", 128'(tx), 128'(1));
        chk("rst_tx_idle", 128'(tx_idle), 128'(1));
        chk("rst_terms", 128'({ACK, ERR, RTY}), 128'(0));
        chk("rst_dat_o", 128'(DAT_O), 128'(0));
        rst = 1'b1;

        // 1: reset in the middle of a frame
        wr_byte(8'h55, term);
        chk("t1_ack", 128'(term), 128'(T_ACK));
        exp_q.delete();
        repeat (13) @(posedge clk);
        #1;
        model = line_model(8'h55, 8'h00, 1);
        chk("t1_mid_frame_tx", 128'(tx), 128'(model[11]));
        chk("t1_mid_frame_idle", 128'(tx_idle), 128'(0));
        rst = 1'b0;
        #1;
        chk("t1_tx_at_reset", 128'(tx), 128'(1));
        chk("t1_idle_at_reset", 128'(tx_idle), 128'(1));
        tick(); tick();
        rst = 1'b1;
        wb_xfer(1'b0, A_STAT, 32'h0, term, rd);
        chk("t1_status_term", 128'(term), 128'(T_ACK));
        chk("t1_status", 128'(rd), 128'(32'h2));
        prev  = tx;
        edges = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx !== prev) edges++;
            prev = tx;
        end
        chk("t1_no_edges", 128'(edges), 128'(0));
        mon_en = 1'b1;

        // 2: single 'A'
        wr_byte(8'h41, term);
        chk("t2_ack", 128'(term), 128'(T_ACK));
        capture(40, cap, lat);
        chk("t2_latency", 128'(lat), 128'(2));
        chk("t2_frame", cap, line_model(8'h41, 8'h00, 1));
        repeat (2) @(negedge clk);
        chk("t2_idle_after", 128'(tx_idle), 128'(1));

        // 3: two frames with no gap
        fork
            begin
                wr_byte(8'h48, t3a);
                wr_byte(8'h69, t3b);
            end
            capture(80, cap3, lat3);
        join
        chk("t3_ack1", 128'(t3a), 128'(T_ACK));
        chk("t3_ack2", 128'(t3b), 128'(T_ACK));
        chk("t3_frames", cap3, line_model(8'h48, 8'h69, 2));
        wait_idle(200, "t3_idle");
        sb_check("t3");

        // 4: fill shifter + FIFO, then overflow and retry
        for (int i = 0; i < 5; i++) begin
            wr_byte(8'($urandom), term);
            chk("t4_fill_ack", 128'(term), 128'(T_ACK));
        end
        b6 = 8'($urandom);
        wr_byte(b6, term);
        chk("t4_full_rty", 128'(term), 128'(T_RTY));
        wb_xfer(1'b0, A_STAT, 32'h0, term, rd);
        chk("t4_status", 128'(rd), 128'(32'h5));
        for (int r = 0; r < 60; r++) begin
            wr_byte(b6, term);
            if (term == T_ACK) break;
        end
        chk("t4_retry_ack", 128'(term), 128'(T_ACK));
        wait_idle(600, "t4_idle");
        sb_check("t4");

        // 5: status, error terminations, read of DATA
        wb_xfer(1'b0, A_STAT, 32'h0, term, rd);
        chk("t5_stat_term", 128'(term), 128'(T_ACK));
        chk("t5_stat_val", 128'(rd), 128'(32'h2));
        @(negedge clk);
        chk("t5_dat_o_outside_ack", 128'(DAT_O), 128'(0));
        wb_xfer(1'b1, A_STAT, 32'hff00_0000, term, rd);
        chk("t5_wr_status_err", 128'(term), 128'(T_ERR));
        wb_xfer(1'b0, A_R2, 32'h0, term, rd);
        chk("t5_rd_adr8_err", 128'(term), 128'(T_ERR));
        wb_xfer(1'b1, A_R2, 32'h4200_0000, term, rd);
        chk("t5_wr_adr8_err", 128'(term), 128'(T_ERR));
        wb_xfer(1'b1, A_R3, 32'h4300_0000, term, rd);
        chk("t5_wr_adrc_err", 128'(term), 128'(T_ERR));
        wb_xfer(1'b0, A_DATA, 32'h0, term, rd);
        chk("t5_rd_data_term", 128'(term), 128'(T_ACK));
        chk("t5_rd_data_val", 128'(rd), 128'(0));
        wb_xfer(1'b0, A_STAT, 32'h0, term, rd);
        chk("t5_stat_unchanged", 128'(rd), 128'(32'h2));
        chk("t5_still_idle", 128'(tx_idle), 128'(1));

        // 6: STB held for 10 edges with a fresh byte each cycle
        tick();
        cur = 8'($urandom);
        CYC = 1'b1; STB = 1'b1; WE = 1'b1; ADR = A_DATA; DAT_I = {cur, 24'h0};
        ackv = '0; expv = '0; other = 1'b0; exp_bit = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            exp_bit = !exp_bit;
            expv[k] = exp_bit;
            ackv[k] = ACK;
            other   = other | ERR | RTY;
            if (ACK) exp_q.push_back(cur);
            cur   = 8'($urandom);
            DAT_I = {cur, 24'h0};
        end
        CYC = 1'b0; STB = 1'b0; WE = 1'b0;
        chk("t6_ack_pattern", 128'(ackv), 128'(expv));
        chk("t6_no_err_rty", 128'(other), 128'(0));
        wb_xfer(1'b0, A_STAT, 32'h0, term, rd);
        chk("t6_status_full", 128'(rd), 128'(32'h5));
        wait_idle(800, "t6_idle");
        sb_check("t6");

        // 6b: push on the pop edge, then a push into a full FIFO on the pop edge
        tick();
        one_wr(8'hc3, term);
        chk("t6b_first_ack", 128'(term), 128'(T_ACK));
        tick();
        one_wr(8'h3c, term);
        chk("t6b_second_ack", 128'(term), 128'(T_ACK));
        repeat (38) tick();
        one_wr(8'h5a, term);
        chk("t6b_pushpop_ack", 128'(term), 128'(T_ACK));
        n_ack = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            one_wr(8'($urandom), term);
            if (term != T_ACK) break;
            n_ack++;
        end
        chk("t6b_fill_count", 128'(n_ack), 128'(3));
        chk("t6b_fill_rty", 128'(term), 128'(T_RTY));
        repeat (31) tick();
        one_wr(8'ha5, term);
        chk("t6b_full_on_pop_rty", 128'(term), 128'(T_RTY));
        tick();
        one_wr(8'ha5, term);
        chk("t6b_after_pop_ack", 128'(term), 128'(T_ACK));
        wait_idle(800, "t6b_idle");
        sb_check("t6b");

        // 7: random bytes with random gaps, retried on RTY
        for (int n = 0; n < 20; n++) begin
            cur = 8'($urandom);
            repeat ($urandom_range(0, 3)) tick();
            for (int r = 0; r < 100; r++) begin
                wr_byte(cur, term);
                if (term == T_ACK) break;
                chk("t7_rty", 128'(term), 128'(T_RTY));
            end
            chk("t7_ack", 128'(term), 128'(T_ACK));
        end
        wait_idle(2000, "t7_idle");
        sb_check("t7");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
